pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch in the IF stage.
//  Chooses the next PC from PC+4, the branch target or the jump target, and drives PCSel to the 32-bit PC select mux.
//  Runs a valid/ready request handshake with instruction memory, and supports stalls and redirects.
//  Redirects squash in-flight fetches and pulse Flush toward the IF/ID register.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  CNT_W     16             width of the saturating redirect counter
// PORTS
//  Clk           in   1      clock; all state updates on rising edge
//  Rst           in   1      reset, asynchronous, active-low
//  Stall         in   1      hazard unit: do not start a new fetch
//  BranchTaken   in   1      branch resolved taken this cycle
//  BranchTarget  in   32     branch target address
//  Jump          in   1      jump decoded this cycle
//  JumpTarget    in   32     jump target address
//  IMemReady     in   1      imem accepts request / instruction returned
//  IMemReq       out  1      fetch request for address PC
//  PC            out  32     current fetch address
//  PCPlus4       out  32     PC + 4 (combinational)
//  PCSel         out  2      mux select: 00 seq, 01 branch, 10 jump (comb)
//  InstrValid    out  1      instruction from previous-cycle handshake is usable
//  Flush         out  1      one-cycle pulse: kill IF/ID contents
//  RedirectCnt   out  CNT_W  number of accepted redirects, saturating
// BEHAVIOUR
//  Reset (Rst=0, async)
//   - PC=RESET_PC, state=BOOT; IMemReq, InstrValid, Flush and RedirectCnt are 0.
//   - Asserting reset mid-handshake drops IMemReq immediately; the in-flight fetch is abandoned.
//  Handshake
//   - A transfer occurs on a cycle where IMemReq=1 and IMemReady=1.
//   - While IMemReq=1 and IMemReady=0, IMemReq and PC are held stable; no retraction is allowed.
//  Redirect
//   - redir = BranchTaken | Jump.
//   - Priority: branch over jump.
//   - Target low 2 bits are forced to 2'b00.
//   - PCSel = 01 if BranchTaken, else 10 if Jump, else 00.
//   - Each redir cycle: Flush=1 on the next cycle, and RedirectCnt+1 (holds at all-ones).
//  States
//   - BOOT: IMemReq=0. Next state is FETCH.
//   - FETCH: IMemReq=1.
//     - redir & Ready: PC<=target, InstrValid<=0. Next state is STALL if Stall, else FETCH.
//     - redir & !Ready: latch target into pend. Next state is REDIR.
//     - !redir & Ready: PC<=PC+4, InstrValid<=1. Next state is STALL if Stall, else FETCH.
//     - !redir & !Ready: hold PC, InstrValid<=0.
//   - STALL: IMemReq=0, InstrValid<=0, PC held.
//     - redir: PC<=target.
//     - Next state is FETCH when Stall=0.
//   - REDIR: IMemReq=1 at the old PC (finishing the doomed fetch), InstrValid<=0.
//     - A new redir overwrites pend and pulses Flush again.
//     - On Ready: PC<=pend, or the new target if redir in the same cycle. Next state is STALL if Stall, else FETCH.
//  Timing and widths
//   - InstrValid is registered: it is high exactly in the cycle after a non-squashed transfer.
//   - Stall has no effect on a pending (unaccepted) request.
//   - PC+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
// TESTING
//  - Reset release, Ready=1, no Stall: PC sequence 0,4,8,C over cycles 2..5; InstrValid high from cycle 3.
//  - Ready low for 3 cycles in FETCH at PC=8: IMemReq and PC=8 held; PC goes to C after Ready; one InstrValid pulse.
//  - BranchTaken=1, Target=0x40, Jump=1, JumpTarget=0x80 in one cycle with Ready=1: PCSel=01, PC=0x40, Flush=1 for one cycle, RedirectCnt+1.
//  - Jump to 0x103 while Ready=0: enters REDIR; when Ready rises, PC=0x100, InstrValid stays 0 for the squashed fetch.
//  - Stall=1 after a transfer: IMemReq=0 and PC held; BranchTaken to 0x20 during stall gives PC=0x20; Stall=0 resumes fetch at 0x20.
//  - Rst low while REDIR pending: PC=RESET_PC, IMemReq=0 asynchronously; RESET_PC=0xFFFFFFFC wraps to 0 after one transfer.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// IF-stage program counter owner: picks the next PC, runs the imem valid/ready
// request handshake, and squashes in-flight fetches on branch/jump redirects.
//
// state | meaning
// BOOT  | first cycle out of reset, no request issued
// FETCH | request for PC outstanding, advance or redirect on Ready
// STALL | hazard hold, no request, PC may still be redirected
// REDIR | finishing a doomed fetch at the old PC, target parked in pend
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             IMemReady,
  output logic             IMemReq,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic [1:0]       PCSel,
  output logic             InstrValid,
  output logic             Flush,
  output logic [CNT_W-1:0] RedirectCnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    STALL = 2'b10,
    REDIR = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic             instr_valid_q, instr_valid_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic             redir;
  logic [31:0]      target_raw;
  logic [31:0]      target;
  logic [31:0]      pc_plus4;

  always_comb begin
    redir      = BranchTaken | Jump;
    // Branch wins over jump; targets are forced word-aligned.
    target_raw = BranchTaken ? BranchTarget : JumpTarget;
    target     = target_raw & 32'hFFFF_FFFC;
    pc_plus4   = pc_q + 32'd4;
    if (BranchTaken)
      PCSel = 2'b01;
    else if (Jump)
      PCSel = 2'b10;
    else
      PCSel = 2'b00;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    instr_valid_d = 1'b0;
    flush_d       = redir;
    redir_cnt_d   = redir_cnt_q;
    IMemReq       = 1'b0;

    if (redir && !(&redir_cnt_q))
      redir_cnt_d = redir_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        IMemReq = 1'b1;
        if (IMemReady) begin
          pc_d          = redir ? target : pc_plus4;
          instr_valid_d = !redir;
          state_d       = Stall ? STALL : FETCH;
        end else if (redir) begin
          pend_d  = target;
          state_d = REDIR;
        end
      end
      STALL: begin
        if (redir)
          pc_d = target;
        if (!Stall)
          state_d = FETCH;
      end
      REDIR: begin
        // Request stays up at the old PC until imem takes it; the reply is discarded.
        IMemReq = 1'b1;
        if (redir)
          pend_d = target;
        if (IMemReady) begin
          pc_d    = redir ? target : pend_q;
          state_d = Stall ? STALL : FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pend_q        <= RESET_PC;
      instr_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      redir_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      instr_valid_q <= instr_valid_d;
      flush_q       <= flush_d;
      redir_cnt_q   <= redir_cnt_d;
    end
  end

  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign InstrValid  = instr_valid_q;
  assign Flush       = flush_q;
  assign RedirectCnt = redir_cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: per-cycle expectations are queued as
// stimulus is driven and compared after the clock edge that produces them.
module tb_pc_fetch_sequencer;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        IMemReady;

  logic        req_a, iv_a, fl_a;
  logic [31:0] pc_a, pc4_a;
  logic [1:0]  sel_a;
  logic [15:0] cnt_a;

  logic        req_b, iv_b, fl_b;
  logic [31:0] pc_b, pc4_b;
  logic [1:0]  sel_b;
  logic [1:0]  cnt_b;

  int n_asserts = 0;
  int n_fails   = 0;
  int exp_cnt   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        req;
    logic        iv;
    logic        fl;
    logic [15:0] cnt;
    logic [1:0]  cnt_sat;
  } exp_t;

  exp_t sb[$];

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .IMemReady(IMemReady),
    .IMemReq(req_a), .PC(pc_a), .PCPlus4(pc4_a), .PCSel(sel_a),
    .InstrValid(iv_a), .Flush(fl_a), .RedirectCnt(cnt_a)
  );

  // Second instance: wrap-around reset PC and a 2-bit counter to reach saturation.
  pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_w (
    .Clk(Clk), .Rst(Rst), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .IMemReady(IMemReady),
    .IMemReq(req_b), .PC(pc_b), .PCPlus4(pc4_b), .PCSel(sel_b),
    .InstrValid(iv_b), .Flush(fl_b), .RedirectCnt(cnt_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic rdy,
                      input logic [1:0] e_sel, input logic [31:0] e_pc,
                      input logic e_req, input logic e_iv, input logic e_fl);
    exp_t e;
    Stall        = st;
    BranchTaken  = br;
    BranchTarget = bt;
    Jump         = jp;
    JumpTarget   = jt;
    IMemReady    = rdy;
    if (br || jp) exp_cnt++;
    e.tag     = tag;
    e.pc      = e_pc;
    e.req     = e_req;
    e.iv      = e_iv;
    e.fl      = e_fl;
    e.cnt     = 16'(exp_cnt);
    e.cnt_sat = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
    sb.push_back(e);
    #1;
    chk({tag, ".pcsel"}, {30'd0, sel_a}, {30'd0, e_sel});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"},    pc_a, e.pc);
    chk({e.tag, ".pc4"},   pc4_a, e.pc + 32'd4);
    chk({e.tag, ".req"},   {31'd0, req_a}, {31'd0, e.req});
    chk({e.tag, ".iv"},    {31'd0, iv_a}, {31'd0, e.iv});
    chk({e.tag, ".flush"}, {31'd0, fl_a}, {31'd0, e.fl});
    chk({e.tag, ".cnt"},   {16'd0, cnt_a}, {16'd0, e.cnt});
    chk({e.tag, ".cnt_sat"}, {30'd0, cnt_b}, {30'd0, e.cnt_sat});
  endtask

  initial begin
    Rst = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    Jump = 1'b0; JumpTarget = '0; IMemReady = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    chk("rst.pc",    pc_a, 32'h0);
    chk("rst.req",   {31'd0, req_a}, 32'd0);
    chk("rst.iv",    {31'd0, iv_a}, 32'd0);
    chk("rst.flush", {31'd0, fl_a}, 32'd0);
    chk("rst.cnt",   {16'd0, cnt_a}, 32'd0);
    chk("rst.pc_w",  pc_b, 32'hFFFF_FFFC);
    Rst = 1'b1;

    // Sequential fetch, then Ready held low at PC=8.
    step("boot",   0, 0, 0, 0, 0, 1, 2'b00, 32'h0, 1, 0, 0);
    step("seq0",   0, 0, 0, 0, 0, 1, 2'b00, 32'h4, 1, 1, 0);
    chk("wrap.pc_w", pc_b, 32'h0);
    step("seq4",   0, 0, 0, 0, 0, 1, 2'b00, 32'h8, 1, 1, 0);
    step("hold1",  0, 0, 0, 0, 0, 0, 2'b00, 32'h8, 1, 0, 0);
    step("hold2",  1, 0, 0, 0, 0, 0, 2'b00, 32'h8, 1, 0, 0);
    step("hold3",  0, 0, 0, 0, 0, 0, 2'b00, 32'h8, 1, 0, 0);
    step("seq8",   0, 0, 0, 0, 0, 1, 2'b00, 32'hC, 1, 1, 0);

    // Branch and jump together: branch wins.
    step("brjp",   0, 1, 32'h40, 1, 32'h80, 1, 2'b01, 32'h40, 1, 0, 1);

    // Jump to an unaligned target while imem is busy.
    step("jbusy",  0, 0, 0, 1, 32'h103, 0, 2'b10, 32'h40, 1, 0, 1);
    step("rwait",  0, 0, 0, 0, 0, 0, 2'b00, 32'h40, 1, 0, 0);
    step("rdone",  0, 0, 0, 0, 0, 1, 2'b00, 32'h100, 1, 0, 0);

    // Stall after a transfer, branch during the stall, then resume.
    step("xfer_st", 1, 0, 0, 0, 0, 1, 2'b00, 32'h104, 0, 1, 0);
    step("stall1",  1, 0, 0, 0, 0, 1, 2'b00, 32'h104, 0, 0, 0);
    step("st_br",   1, 1, 32'h20, 0, 0, 1, 2'b01, 32'h20, 0, 0, 1);
    step("unstall", 0, 0, 0, 0, 0, 1, 2'b00, 32'h20, 1, 0, 0);
    step("seq20",   0, 0, 0, 0, 0, 1, 2'b00, 32'h24, 1, 1, 0);

    // Pending redirect overwritten before imem accepts.
    step("p_jp",   0, 0, 0, 1, 32'h200, 0, 2'b10, 32'h24, 1, 0, 1);
    step("p_br",   0, 1, 32'h300, 0, 0, 0, 2'b01, 32'h24, 1, 0, 1);
    step("p_done", 0, 0, 0, 0, 0, 1, 2'b00, 32'h300, 1, 0, 0);

    // New redirect on the very cycle the doomed fetch completes.
    step("q_jp",   0, 0, 0, 1, 32'h400, 0, 2'b10, 32'h300, 1, 0, 1);
    step("q_brrd", 0, 1, 32'h502, 0, 0, 1, 2'b01, 32'h500, 1, 0, 1);
    step("seq500", 0, 0, 0, 0, 0, 1, 2'b00, 32'h504, 1, 1, 0);

    // Asynchronous reset while a redirect is pending.
    step("r_jp",   0, 0, 0, 1, 32'h600, 0, 2'b10, 32'h504, 1, 0, 1);
    #2;
    Rst = 1'b0;
    #1;
    chk("arst.pc",    pc_a, 32'h0);
    chk("arst.req",   {31'd0, req_a}, 32'd0);
    chk("arst.cnt",   {16'd0, cnt_a}, 32'd0);
    chk("arst.flush", {31'd0, fl_a}, 32'd0);
    chk("arst.pc_w",  pc_b, 32'hFFFF_FFFC);
    chk("arst.req_w", {31'd0, req_b}, 32'd0);
    chk("arst.pc4_w", pc4_b, 32'h0);
    exp_cnt = 0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    JumpTarget = '0;
    Jump = 1'b0;

    step("boot2",  0, 0, 0, 0, 0, 1, 2'b00, 32'h0, 1, 0, 0);
    chk("boot2.pc_w", pc_b, 32'hFFFF_FFFC);
    step("seq0b",  0, 0, 0, 0, 0, 1, 2'b00, 32'h4, 1, 1, 0);
    chk("wrap2.pc_w", pc_b, 32'h0);
    chk("wrap2.iv_w", {31'd0, iv_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
